// File: rtl/eth_log_arbiter.sv
// Round-robin, packet-atomic arbiter merging up to 8 AXI4-Stream log producers onto one tagged, registered log channel.
// Define ETH_LOG_ARB_TIMEOUT_EN to close records from producers that stall mid-record for C_TIMEOUT cycles.
module eth_log_arbiter #(
    parameter int C_NUM_SOURCES    = 4,
    parameter int C_AXIS_LOG_WIDTH = 64,
    parameter int C_TIMEOUT        = 256
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [C_NUM_SOURCES*C_AXIS_LOG_WIDTH-1:0]   s_axis_log_tdata,
    input  logic [C_NUM_SOURCES-1:0]                    s_axis_log_tlast,
    input  logic [C_NUM_SOURCES-1:0]                    s_axis_log_tvalid,
    output logic [C_NUM_SOURCES-1:0]                    s_axis_log_tready,
    output logic [C_AXIS_LOG_WIDTH-1:0]                 m_axis_log_tdata,
    output logic                                        m_axis_log_tlast,
    output logic [2:0]                                  m_axis_log_tid,
    output logic                                        m_axis_log_tvalid,
    input  logic                                        m_axis_log_tready,
    output logic [15:0]                                 timeout_count
);

`ifdef ETH_LOG_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
`else
    typedef enum logic [0:0] {IDLE, BUSY} state_t;
`endif

    localparam int W = C_AXIS_LOG_WIDTH;

    state_t                 state, state_nxt;
    logic [2:0]             grant, last_grant, pick;
    logic                   found;
    logic [7:0]             tvalid_pad, tlast_pad;
    logic [C_NUM_SOURCES-1:0] grant_mask;
    logic [W-1:0]           sel_data;
    logic                   out_free, accept, load_synth, timed_out;

    // Zero-padded to 8 so a 3-bit grant can index them for any N.
    assign tvalid_pad = 8'(s_axis_log_tvalid);
    assign tlast_pad  = 8'(s_axis_log_tlast);
    assign out_free   = !m_axis_log_tvalid || m_axis_log_tready;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned k = 1; k <= 32'(C_NUM_SOURCES); k++) begin
            if (!found && tvalid_pad[3'((32'(last_grant) + k) % 32'(C_NUM_SOURCES))]) begin
                found = 1'b1;
                pick  = 3'((32'(last_grant) + k) % 32'(C_NUM_SOURCES));
            end
        end
    end

    always_comb begin
        grant_mask = '0;
        sel_data   = '0;
        for (int unsigned i = 0; i < 32'(C_NUM_SOURCES); i++) begin
            if (grant == 3'(i)) begin
                grant_mask[i] = 1'b1;
                sel_data      = s_axis_log_tdata[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt         = state;
        s_axis_log_tready = '0;
        accept            = 1'b0;
        load_synth        = 1'b0;
        case (state)
            IDLE: if (found) state_nxt = BUSY;
            BUSY: begin
                if (timed_out) begin
`ifdef ETH_LOG_ARB_TIMEOUT_EN
                    if (out_free) begin
                        load_synth = 1'b1;
                        state_nxt  = DRAIN;
                    end
`endif
                end else begin
                    s_axis_log_tready = out_free ? grant_mask : '0;
                    accept            = out_free && tvalid_pad[grant];
                    if (accept && tlast_pad[grant]) state_nxt = IDLE;
                end
            end
`ifdef ETH_LOG_ARB_TIMEOUT_EN
            DRAIN: begin
                s_axis_log_tready = grant_mask;
                if (tvalid_pad[grant] && tlast_pad[grant]) state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant             <= '0;
            last_grant        <= 3'(C_NUM_SOURCES - 1);
            m_axis_log_tdata  <= '0;
            m_axis_log_tlast  <= 1'b0;
            m_axis_log_tid    <= '0;
            m_axis_log_tvalid <= 1'b0;
        end else begin
            if (state == IDLE && found) begin
                grant      <= pick;
                last_grant <= pick;
            end
            if (accept) begin
                m_axis_log_tdata  <= sel_data;
                m_axis_log_tlast  <= tlast_pad[grant];
                m_axis_log_tid    <= grant;
                m_axis_log_tvalid <= 1'b1;
            end else if (load_synth) begin
                m_axis_log_tdata  <= '1;
                m_axis_log_tlast  <= 1'b1;
                m_axis_log_tid    <= grant;
                m_axis_log_tvalid <= 1'b1;
            end else if (m_axis_log_tready) begin
                m_axis_log_tvalid <= 1'b0;
            end
        end
    end

`ifdef ETH_LOG_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_CYCLES = 16'(C_TIMEOUT);

    logic [15:0] stall_cnt, tmo_cnt;

    // Counter holds at the limit while the synthetic beat waits for a free output register.
    assign timed_out     = (state == BUSY) && (stall_cnt >= TIMEOUT_CYCLES);
    assign timeout_count = tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            tmo_cnt   <= '0;
        end else begin
            if (state != BUSY || accept)
                stall_cnt <= '0;
            else if (!tvalid_pad[grant] && !timed_out)
                stall_cnt <= stall_cnt + 16'd1;
            if (load_synth && tmo_cnt != '1)
                tmo_cnt <= tmo_cnt + 16'd1;
        end
    end
`else
    logic unused_timeout;

    assign timed_out      = 1'b0;
    assign timeout_count  = '0;
    assign unused_timeout = ^16'(C_TIMEOUT);
`endif

endmodule

// File: tb/tb_eth_log_arbiter.sv
// Scoreboard bench for eth_log_arbiter: per-source stimulus queue, expected output beats queued in grant order.
module tb_eth_log_arbiter;

    localparam int N = 4;
    localparam int W = 64;

    typedef struct {
        int           src;
        logic [W-1:0] data;
        logic         last;
    } stim_t;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        logic [2:0]   tid;
        int           gap;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] s_tdata;
    logic [N-1:0]   s_tlast, s_tvalid, s_tready;
    logic [W-1:0]   m_tdata;
    logic           m_tlast, m_tvalid, m_tready;
    logic [2:0]     m_tid;
    logic [15:0]    timeout_count;

    stim_t        stim[$];
    exp_t         sb[$];
    int           n_chk = 0, n_pass = 0, cyc = 0, last_out = 0;
    logic [N-1:0] src_en;
    logic         pend, lat_en;
    logic [W-1:0] pend_data;

    eth_log_arbiter #(
        .C_NUM_SOURCES    (N),
        .C_AXIS_LOG_WIDTH (W),
        .C_TIMEOUT        (8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .s_axis_log_tdata  (s_tdata),
        .s_axis_log_tlast  (s_tlast),
        .s_axis_log_tvalid (s_tvalid),
        .s_axis_log_tready (s_tready),
        .m_axis_log_tdata  (m_tdata),
        .m_axis_log_tlast  (m_tlast),
        .m_axis_log_tid    (m_tid),
        .m_axis_log_tvalid (m_tvalid),
        .m_axis_log_tready (m_tready),
        .timeout_count     (timeout_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic send(input int src, input logic [W-1:0] data, input logic last);
        stim.push_back('{src: src, data: data, last: last});
    endtask

    task automatic expect_beat(input logic [W-1:0] data, input logic last, input logic [2:0] tid, input int gap);
        sb.push_back('{data: data, last: last, tid: tid, gap: gap});
    endtask

    function automatic int find_src(input int s);
        foreach (stim[k]) if (stim[k].src == s) return k;
        return -1;
    endfunction

    task automatic drive();
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        for (int i = 0; i < N; i++) begin
            int idx = find_src(i);
            if (idx >= 0 && src_en[i]) begin
                s_tvalid[i]       = 1'b1;
                s_tlast[i]        = stim[idx].last;
                s_tdata[i*W +: W] = stim[idx].data;
            end
        end
    endtask

    task automatic apply();
        drive();
        #1;
    endtask

    // Observe at the falling edge the handshakes that the next rising edge commits.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (pend) begin
            check("lat_valid", m_tvalid, 1'b1);
            check("lat_data", m_tdata, pend_data);
            pend = 1'b0;
        end
        if (!rst && m_tvalid && m_tready) begin
            check("sb_avail", sb.size() > 0, 1'b1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("out_data", m_tdata, e.data);
                check("out_last", m_tlast, e.last);
                check("out_tid", m_tid, e.tid);
                if (e.gap > 0) check("out_gap", cyc - last_out, e.gap);
            end
            last_out = cyc;
        end
        if (!rst && m_tvalid && !m_tready) check("bp_rdy", s_tready, '0);
        for (int i = 0; i < N; i++) begin
            if (s_tvalid[i] && s_tready[i]) begin
                int idx = find_src(i);
                if (!rst && lat_en) begin
                    pend      = 1'b1;
                    pend_data = stim[idx].data;
                end
                stim.delete(idx);
            end
        end
        @(posedge clk);
        #1;
        drive();
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        stim.delete();
        sb.delete();
        pend     = 1'b0;
        lat_en   = 1'b1;
        src_en   = '1;
        m_tready = 1'b1;
        drive();
        tick();
        tick();
        check("rst_tvalid", m_tvalid, 1'b0);
        check("rst_tlast", m_tlast, 1'b0);
        check("rst_tdata", m_tdata, '0);
        check("rst_tid", m_tid, '0);
        check("rst_sready", s_tready, '0);
        check("rst_tmo", timeout_count, '0);
        rst = 1'b0;
    endtask

    task automatic run_until_empty(input int budget);
        int k = 0;
        while ((sb.size() > 0 || stim.size() > 0) && k < budget) begin
            tick();
            k++;
        end
        check("sb_drained", sb.size(), '0);
        check("stim_drained", stim.size(), '0);
    endtask

    initial begin
        logic [3:0] pat;

        // Single source, one arbitration bubble before the first beat
        do_reset();
        send(2, 64'hA1, 1'b0); send(2, 64'hA2, 1'b0); send(2, 64'hA3, 1'b1);
        expect_beat(64'hA1, 1'b0, 3'd2, 0);
        expect_beat(64'hA2, 1'b0, 3'd2, 1);
        expect_beat(64'hA3, 1'b1, 3'd2, 1);
        apply();
        check("sgl_idle", s_tready, '0);
        tick();
        check("sgl_grant", s_tready, 4'b0100);
        check("sgl_nobeat", m_tvalid, 1'b0);
        run_until_empty(20);

        // All sources valid: grant order 0,1,2,3,0 with one bubble between records
        do_reset();
        for (int s = 0; s < N; s++) begin
            send(s, 64'h100 + 64'(s * 16), 1'b0);
            send(s, 64'h101 + 64'(s * 16), 1'b1);
        end
        send(0, 64'h0C0, 1'b0); send(0, 64'h0C1, 1'b1);
        for (int s = 0; s < N; s++) begin
            expect_beat(64'h100 + 64'(s * 16), 1'b0, 3'(s), (s == 0) ? 0 : 2);
            expect_beat(64'h101 + 64'(s * 16), 1'b1, 3'(s), 1);
        end
        expect_beat(64'h0C0, 1'b0, 3'd0, 2);
        expect_beat(64'h0C1, 1'b1, 3'd0, 1);
        apply();
        run_until_empty(60);

        // Backpressure: m_tready 1,0,0,1 during a 4-beat record from source 1
        do_reset();
        for (int b = 0; b < 4; b++) begin
            send(1, 64'hB1 + 64'(b), b == 3);
            expect_beat(64'hB1 + 64'(b), b == 3, 3'd1, 0);
        end
        apply();
        tick();
        pat = 4'b1001;
        for (int k = 0; k < 30 && sb.size() > 0; k++) begin
            m_tready = (k < 4) ? pat[k] : 1'b1;
            tick();
        end
        m_tready = 1'b1;
        run_until_empty(10);

        // Fairness: source 3 takes the grant straight after source 0's first record
        do_reset();
        send(0, 64'hF0, 1'b0); send(0, 64'hF1, 1'b1);
        send(0, 64'hF2, 1'b0); send(0, 64'hF3, 1'b1);
        send(3, 64'h3F0, 1'b0); send(3, 64'h3F1, 1'b1);
        expect_beat(64'hF0, 1'b0, 3'd0, 0);
        expect_beat(64'hF1, 1'b1, 3'd0, 1);
        expect_beat(64'h3F0, 1'b0, 3'd3, 2);
        expect_beat(64'h3F1, 1'b1, 3'd3, 1);
        expect_beat(64'hF2, 1'b0, 3'd0, 2);
        expect_beat(64'hF3, 1'b1, 3'd0, 1);
        apply();
        run_until_empty(40);

`ifdef ETH_LOG_ARB_TIMEOUT_EN
        // Stall timeout: synthetic all-ones close, late beats discarded, source 2 next
        do_reset();
        send(1, 64'h1111, 1'b0);
        send(2, 64'h2201, 1'b0); send(2, 64'h2202, 1'b1);
        expect_beat(64'h1111, 1'b0, 3'd1, 0);
        expect_beat('1, 1'b1, 3'd1, 9);
        expect_beat(64'h2201, 1'b0, 3'd2, 0);
        expect_beat(64'h2202, 1'b1, 3'd2, 1);
        apply();
        for (int k = 0; k < 10 && find_src(1) >= 0; k++) tick();
        check("tmo_first_beat", find_src(1) < 0, 1'b1);
        src_en[1] = 1'b0;
        send(1, 64'hDEAD1, 1'b0); send(1, 64'hDEAD2, 1'b1);
        apply();
        for (int k = 0; k < 14; k++) tick();
        check("tmo_count", timeout_count, 16'd1);
        lat_en    = 1'b0;
        src_en[1] = 1'b1;
        apply();
        run_until_empty(40);
        check("tmo_count_end", timeout_count, 16'd1);
`else
        check("tmo_tied", timeout_count, '0);
`endif

        // Reset during the second beat of a record abandons it
        do_reset();
        for (int s = 0; s < N; s++)
            for (int b = 0; b < 3; b++) send(s, 64'hC00 + 64'(s * 16 + b), b == 2);
        apply();
        tick();
        tick();
        check("mid_beat2_rdy", s_tready, 4'b0001);
        rst = 1'b1;
        tick();
        check("mid_tvalid", m_tvalid, 1'b0);
        check("mid_sready", s_tready, '0);
        check("mid_tmo", timeout_count, '0);
        stim.delete();
        sb.delete();
        for (int s = 0; s < N; s++) begin
            for (int b = 0; b < 2; b++) begin
                send(s, 64'hD00 + 64'(s * 16 + b), b == 1);
                expect_beat(64'hD00 + 64'(s * 16 + b), b == 1, 3'(s), 0);
            end
        end
        rst = 1'b0;
        apply();
        tick();
        check("mid_first_grant", s_tready, 4'b0001);
        run_until_empty(60);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/eth_log_arbiter.md
# eth_log_arbiter

Round-robin, packet-atomic arbiter that shares one AXI4-Stream log channel between up to 8 log producers (latency measurers, frame detectors, stats collectors) feeding the single log DMA path. A source keeps its grant from its first beat until its `tlast`, so log records are never interleaved. The output is registered and tagged with the source index. An optional stall timeout closes packets from producers that stall mid-record.

## Interface
Parameters:
- `C_NUM_SOURCES`, default 4: number of log sources, 2..8.
- `C_AXIS_LOG_WIDTH`, default 64: log beat width in bits.
- `C_TIMEOUT`, default 256: consecutive stall cycles before forced close, 2..65535. Used only with the timeout feature.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `s_axis_log_tdata`, in, N*W: source i occupies bits [i*W +: W].
- `s_axis_log_tlast`, in, N: per-source end of record.
- `s_axis_log_tvalid`, in, N: per-source valid.
- `s_axis_log_tready`, out, N: per-source ready.
- `m_axis_log_tdata`, out, W: arbitrated beat.
- `m_axis_log_tlast`, out, 1: end of record.
- `m_axis_log_tid`, out, 3: index of the source that produced the beat.
- `m_axis_log_tvalid`, out, 1: output valid.
- `m_axis_log_tready`, in, 1: output ready.
- `timeout_count`, out, 16: saturating count of forced closes.

## Operation
- **FSM states:** IDLE, BUSY, DRAIN. DRAIN exists only with the timeout feature.
- **IDLE:**
  - Pick the first i with `tvalid[i]=1`, scanning from `last_grant+1` modulo N.
  - If one is found: `grant<=i`, `last_grant<=i`, go to BUSY.
  - If none: stay in IDLE.
  - No beat is accepted in IDLE.
- **BUSY:**
  - `s_tready[grant] = !m_tvalid || m_tready`. All other `s_tready` bits are 0.
  - On an accepted beat, the output register loads `tdata`, `tlast` and `tid=grant`.
  - When the accepted beat has `tlast=1`, go to IDLE.
- **Output register:**
  - `m_tvalid` is set on load.
  - It is cleared on `m_tready` when no new beat loads in the same cycle.
  - Data is held stable while `m_tvalid && !m_tready`.
- **Fairness:** a source that just finished has the lowest priority in the next arbitration. Any source with `tvalid` held high is granted within N-1 other records.
- **Unused inputs:** sources whose `tvalid` is 0 are never granted. Index bits ≥ N are ignored.

## Timing
- **Latency:** a beat accepted at cycle t is visible on `m_axis_log_*` at t+1.
- **Arbitration bubble:** exactly one IDLE cycle between the last beat of one record and the first beat of the next. Peak throughput is L/(L+1) beats per cycle for L-beat records.
- **Output stall:** with `m_tready=0` and `m_tvalid=1`, the granted source sees `tready=0`. No beat is lost or duplicated.
- **Simultaneous events:** when `m_tready` consumes a beat and a new beat loads in the same cycle, `m_tvalid` stays 1.
- **Values after reset:**
  - `m_axis_log_tvalid=0`, `tlast=0`, `tdata=0`, `tid=0`.
  - All `s_tready=0`.
  - `timeout_count=0`, state IDLE.
  - `last_grant=N-1`, so source 0 has first priority.
- **Reset mid-record:** the partial record is abandoned with no terminating beat. Downstream must be reset together with this block.

## Configuration
- Macro: `ETH_LOG_ARB_TIMEOUT_EN`.
- **Defined:**
  - In BUSY, a 16-bit counter increments each cycle that `tvalid[grant]=0`. It clears on every accepted beat and on entry to BUSY.
  - When the counter reaches `C_TIMEOUT`, a synthetic beat is loaded as soon as the output register is free: `tdata` all ones, `tlast=1`, `tid=grant`.
  - `timeout_count` increments, saturating at 0xFFFF, and the FSM enters DRAIN.
  - In DRAIN, `s_tready[grant]=1` and the source's beats are discarded up to and including its `tlast`. The FSM then returns to IDLE.
- **Not defined:**
  - No counter and no DRAIN state.
  - A stalled source holds the grant indefinitely.
  - `timeout_count` is tied to 0.

## Test plan
- **Single source:** with N=4, source 2 sends 3 beats (0xA1, 0xA2, 0xA3 with last) while `m_tready=1`. Output shows the same 3 beats, `tid=2`, each 1 cycle after acceptance, with one IDLE cycle before the first beat.
- **All sources:** all 4 sources hold a 2-beat record valid from reset. Grant order is 0,1,2,3, then 0 again. Records are never interleaved, with exactly one bubble between records.
- **Backpressure:** `m_tready` toggles 1,0,0,1 during a 4-beat record from source 1. All 4 beats appear in order with no duplicates. `s_tready[1]` is 0 whenever `m_tvalid && !m_tready`.
- **Fairness:** source 0 sends records back to back while source 3 is pending. Source 3 is granted immediately after source 0's first record completes.
- **Timeout (macro defined, `C_TIMEOUT`=8):**
  - Source 1 sends 1 beat, then drops `tvalid` for 8 cycles.
  - The output emits a beat of all ones with `tlast=1`, `tid=1`, and `timeout_count` becomes 1.
  - Source 1's late beats up to its `tlast` are discarded.
  - Source 2 is granted next.
- **Reset mid-record:** `rst` is asserted during the second beat of a record. The next cycle shows `m_tvalid=0`, all `s_tready=0`, and `timeout_count=0`. The first post-reset grant goes to source 0 when all sources are valid.
